gs232c_fetch_ctrl: RTL and testbench

Sequences the fetch PC stage against the instruction-fetch bus. It issues fetch requests and generates pc_go when the bus accepts an address. It tracks outstanding requests against free instruction-queue slots and discards in-order responses belonging to fetches killed by a redirect. It sits between the PC stage (consumes pc_go, fe_go, iq_cancel) and the instruction SRAM-like bus.

---
 rtl/gs232c_fetch_pkg.sv | 20 ++
 rtl/gs232c_fetch_outs_trk.sv | 65 ++++++
 rtl/gs232c_fetch_ctrl.sv | 92 +++++++++
 tb/tb_gs232c_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gs232c_fetch_pkg.sv
// gs232c_fetch_pkg: shared constants and state encoding for the fetch controller.
// Optional perf counters in the controller are enabled by defining FETCH_CTRL_PERF_EN.
package gs232c_fetch_pkg;

    localparam int FETCH_MAX_OUTS = 2;
    localparam int FETCH_CNT_W    = 3;
    localparam int FETCH_PERF_W   = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    // Plain-vector aliases so the FSM register can stay a legacy logic vector.
    localparam logic [1:0] ST_IDLE  = FETCH_IDLE;
    localparam logic [1:0] ST_RUN   = FETCH_RUN;
    localparam logic [1:0] ST_DRAIN = FETCH_DRAIN;

endpackage

// File: rtl/gs232c_fetch_outs_trk.sv
// gs232c_fetch_outs_trk: tracks live (outs_cnt) and stale (drop_cnt) in-flight
// fetches and decides whether each in-order response is written to the IQ.
module gs232c_fetch_outs_trk
    import gs232c_fetch_pkg::*;
#(
    parameter int MAX_OUTS = FETCH_MAX_OUTS,
    parameter int CNT_W    = FETCH_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect,
    input  logic             pc_go,
    input  logic             inst_data_ok,
    output logic [CNT_W-1:0] outs_cnt,
    output logic [CNT_W-1:0] total,
    output logic [CNT_W-1:0] total_next,
    output logic             fe_go
);

    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] outs_next;
    logic [CNT_W-1:0] drop_next;
    logic             resp_valid;
    logic             stale_resp;
    logic             live_resp;

    // Classify this cycle's response; stale ones drain first since responses are in order.
    always_comb begin
        total      = outs_cnt + drop_cnt;
        resp_valid = inst_data_ok & (total != '0);
        stale_resp = resp_valid & (drop_cnt != '0);
        live_resp  = resp_valid & (drop_cnt == '0);
        fe_go      = live_resp & ~redirect;
    end

    // A redirect turns every live fetch into a stale one; otherwise accepts and responses net out.
    always_comb begin
        if (redirect) begin
            drop_next = drop_cnt + outs_cnt - CNT_W'(resp_valid);
            outs_next = '0;
        end else begin
            drop_next = drop_cnt - CNT_W'(stale_resp);
            outs_next = outs_cnt + CNT_W'(pc_go) - CNT_W'(live_resp);
        end
        total_next = outs_next + drop_next;
    end

    // Counter registers, cleared immediately on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outs_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            outs_cnt <= outs_next;
            drop_cnt <= drop_next;
        end
    end

    a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset)
        !(inst_data_ok && (total == '0)));

    a_total_bound: assert property (@(posedge clock) disable iff (!reset)
        total <= CNT_W'(MAX_OUTS));

endmodule

// File: rtl/gs232c_fetch_ctrl.sv
// gs232c_fetch_ctrl: fetch FSM and request gating between the PC stage and the
// instruction bus. Define FETCH_CTRL_PERF_EN to add perf_drop/perf_stall counters.
module gs232c_fetch_ctrl
    import gs232c_fetch_pkg::*;
#(
    parameter int MAX_OUTS = FETCH_MAX_OUTS,
    parameter int CNT_W    = FETCH_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_en,
    input  logic             redirect,
    input  logic [CNT_W-1:0] iq_free,
    output logic             inst_req,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    output logic             pc_go,
    output logic             fe_go,
    output logic             iq_cancel,
    output logic             idle
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [FETCH_PERF_W-1:0] perf_drop,
    output logic [FETCH_PERF_W-1:0] perf_stall
`endif
);

    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_OUTS);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] outs_cnt;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] total_next;

    gs232c_fetch_outs_trk #(
        .MAX_OUTS (MAX_OUTS),
        .CNT_W    (CNT_W)
    ) u_outs_trk (
        .clock        (clock),
        .reset        (reset),
        .redirect     (redirect),
        .pc_go        (pc_go),
        .inst_data_ok (inst_data_ok),
        .outs_cnt     (outs_cnt),
        .total        (total),
        .total_next   (total_next),
        .fe_go        (fe_go)
    );

    // Request only when running, not flushing, under the in-flight cap and with IQ room for live data.
    always_comb begin
        inst_req  = (state == ST_RUN) & ~redirect & (total < MAX_LIM) & (outs_cnt < iq_free);
        pc_go     = inst_req & inst_addr_ok;
        iq_cancel = redirect;
        idle      = (state == ST_IDLE) & (total == '0);
    end

    // FSM next state; DRAIN only falls to IDLE once nothing remains in flight.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fetch_en) state_next = ST_RUN;
            ST_RUN:   if (!fetch_en) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (fetch_en)                state_next = ST_RUN;
                else if (total_next == '0)   state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

`ifdef FETCH_CTRL_PERF_EN
    // Count discarded responses and RUN cycles that could not issue for reasons other than a flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_drop  <= '0;
            perf_stall <= '0;
        end else begin
            if (inst_data_ok && (total != '0) && !fe_go) perf_drop <= perf_drop + 1'b1;
            if ((state == ST_RUN) && !inst_req && !redirect) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gs232c_fetch_ctrl.sv
// tb_gs232c_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the in-flight fetches.
module tb_gs232c_fetch_ctrl;

    localparam int MAX_OUTS = 2;
    localparam int CNT_W    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             fetch_en;
    logic             redirect;
    logic [CNT_W-1:0] iq_free;
    logic             inst_req;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic             pc_go;
    logic             fe_go;
    logic             iq_cancel;
    logic             idle;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0]      perf_drop;
    logic [31:0]      perf_stall;
`endif

    gs232c_fetch_ctrl #(
        .MAX_OUTS (MAX_OUTS),
        .CNT_W    (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .redirect     (redirect),
        .iq_free      (iq_free),
        .inst_req     (inst_req),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .pc_go        (pc_go),
        .fe_go        (fe_go),
        .iq_cancel    (iq_cancel),
        .idle         (idle)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_drop    (perf_drop),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: one entry per accepted fetch, oldest first; 1 = still wanted, 0 = killed by redirect.
    bit          inflight[$];
    int          mode;          // 0 idle, 1 run, 2 drain
    int unsigned m_perf_drop;
    int unsigned m_perf_stall;
    logic        exp_req;
    logic        exp_go;
    logic        exp_fe;
    logic        exp_idle;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int liveCount();
        int n = 0;
        foreach (inflight[i]) if (inflight[i]) n++;
        return n;
    endfunction

    task automatic applyStimulus(input logic fe, input logic rd, input logic [CNT_W-1:0] free,
                                 input logic aok, input logic dok);
        fetch_en     = fe;
        redirect     = rd;
        iq_free      = free;
        inst_addr_ok = aok;
        inst_data_ok = (inflight.size() > 0) ? dok : 1'b0;
    endtask

    task automatic computeExpect();
        exp_req  = (mode == 1) && !redirect && (inflight.size() < MAX_OUTS) && (liveCount() < int'(iq_free));
        exp_go   = exp_req && inst_addr_ok;
        exp_fe   = inst_data_ok && (inflight.size() > 0) && inflight[0] && !redirect;
        exp_idle = (mode == 0) && (inflight.size() == 0);
    endtask

    task automatic checkCycle();
        computeExpect();
        checkOutput("inst_req", inst_req, exp_req);
        checkOutput("pc_go", pc_go, exp_go);
        checkOutput("fe_go", fe_go, exp_fe);
        checkOutput("iq_cancel", iq_cancel, redirect);
        checkOutput("idle", idle, exp_idle);
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("perf_drop", perf_drop, m_perf_drop);
        checkOutput("perf_stall", perf_stall, m_perf_stall);
`endif
    endtask

    task automatic advanceModel();
        bit resp;
        resp = inst_data_ok && (inflight.size() > 0);
        if (resp && !exp_fe) m_perf_drop++;
        if (mode == 1 && !exp_req && !redirect) m_perf_stall++;
        if (resp) void'(inflight.pop_front());
        if (redirect) foreach (inflight[i]) inflight[i] = 1'b0;
        if (exp_go) inflight.push_back(1'b1);
        case (mode)
            0: if (fetch_en) mode = 1;
            1: if (!fetch_en) mode = 2;
            default: begin
                if (fetch_en) mode = 1;
                else if (inflight.size() == 0) mode = 0;
            end
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic runCycle(input logic fe, input logic rd, input logic [CNT_W-1:0] free,
                            input logic aok, input logic dok);
        applyStimulus(fe, rd, free, aok, dok);
        #4;
        checkCycle();
        advanceModel();
    endtask

    task automatic fillToMax();
        for (int i = 0; i < 8 && inflight.size() < MAX_OUTS; i++) runCycle(1, 0, 4, 1, 0);
        checkOutput("fill_reached_max", inflight.size(), MAX_OUTS);
    endtask

    task automatic resetMid();
        applyStimulus(1, 0, 4, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_inst_req", inst_req, 0);
        checkOutput("rst_pc_go", pc_go, 0);
        checkOutput("rst_fe_go", fe_go, 0);
        checkOutput("rst_idle", idle, 1);
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("rst_perf_drop", perf_drop, 0);
        checkOutput("rst_perf_stall", perf_stall, 0);
`endif
        inflight.delete();
        mode         = 0;
        m_perf_drop  = 0;
        m_perf_stall = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int   cyc;
        int   acc_at[$];
        logic dok;
        logic fe;

        mode         = 0;
        m_perf_drop  = 0;
        m_perf_stall = 0;
        reset        = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        #3;
        checkOutput("por_idle", idle, 1);
        checkOutput("por_inst_req", inst_req, 0);
        checkOutput("por_pc_go", pc_go, 0);
        checkOutput("por_fe_go", fe_go, 0);
        checkOutput("por_iq_cancel", iq_cancel, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Streaming: every request accepted, each response two cycles after its accept.
        cyc = 0;
        for (int i = 0; i < 14; i++) begin
            dok = (acc_at.size() > 0) && (acc_at[0] + 2 <= cyc);
            runCycle(1, 0, 4, 1, dok);
            if (dok) void'(acc_at.pop_front());
            if (exp_go) acc_at.push_back(cyc);
            cyc++;
        end
        for (int i = 0; i < 6 && inflight.size() > 0; i++) runCycle(1, 0, 4, 0, 1);

        // Redirect with two live fetches and no response: both come back stale.
        fillToMax();
        runCycle(1, 1, 4, 1, 0);
        runCycle(1, 0, 4, 0, 1);
        runCycle(1, 0, 4, 0, 1);
        runCycle(1, 0, 4, 1, 0);
        runCycle(1, 0, 4, 0, 1);

        // Redirect coincident with a response while two are live.
        fillToMax();
        runCycle(1, 1, 4, 0, 1);
        runCycle(1, 0, 4, 0, 1);
        runCycle(1, 0, 4, 0, 0);

        // IQ full, then exactly one slot.
        runCycle(1, 0, 0, 1, 0);
        runCycle(1, 0, 0, 1, 0);
        runCycle(1, 0, 1, 1, 0);
        runCycle(1, 0, 1, 1, 0);
        runCycle(1, 0, 1, 1, 0);
        runCycle(1, 0, 1, 0, 1);

        // Drain to idle, then re-raise fetch_en while draining.
        fillToMax();
        runCycle(0, 0, 4, 1, 0);
        runCycle(0, 0, 4, 1, 1);
        runCycle(0, 0, 4, 1, 1);
        runCycle(0, 0, 4, 1, 0);
        runCycle(0, 0, 4, 1, 0);
        fillToMax();
        runCycle(0, 0, 4, 1, 0);
        runCycle(1, 0, 4, 1, 1);
        runCycle(1, 0, 4, 1, 1);
        runCycle(1, 1, 4, 1, 0);

        // Reset in the middle of traffic with stale and live fetches present.
        fillToMax();
        resetMid();
        runCycle(1, 0, 4, 1, 0);
        runCycle(1, 0, 4, 1, 0);

        // Randomized traffic.
        fe = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) fe = ~fe;
            runCycle(fe,
                     ($urandom_range(0, 11) == 0),
                     CNT_W'($urandom_range(0, 4)),
                     ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
